ifns_enc_arb: RTL and testbench

IFNS_ENC_ARB -- requirements
Module: ifns_enc_arb

---
 rtl/ifns_enc_arb.sv | 164 ++++++++++++++++
 tb/tb_ifns_enc_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ifns_enc_arb.sv
// Two-requester round-robin arbiter feeding an IFNS 17-bit encoder with a one-entry output register.
// Optional per-requester accept counters are built when IFNS_ENC_ARB_STATS_EN is defined.

module encoderIFNS_17di_core (
    input  logic [16:0] data,
    output logic [23:0] code
);

    // Positional code: check bits at 1,2,4,8,16; data fills the other slots 3..22;
    // bit 23 is inverted data parity and bit 24 is even parity over bits 1..23.
    function automatic logic [23:0] ifns_encode(input logic [16:0] d);
        logic [23:0] c;
        logic        par;
        int          k;
        c = 24'd0;
        k = 0;
        for (int p = 1; p <= 22; p++) begin
            if ((p & (p - 32'sd1)) != 32'sd0) begin
                c[p-1] = d[k];
                k      = k + 32'sd1;
            end
        end
        for (int b = 0; b < 5; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 22; p++) begin
                if (((p >> b) & 32'sd1) != 32'sd0) begin
                    par = par ^ c[p-1];
                end
            end
            c[(32'sd1 << b) - 32'sd1] = par;
        end
        c[22] = ~(^d);
        c[23] = ^c[22:0];
        return c;
    endfunction

    // Pure combinational encode of the presented dataword
    always_comb begin
        code = ifns_encode(data);
    end

endmodule

module ifns_enc_arb (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        en,
    input  logic        s0_valid,
    input  logic [16:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [16:0] s1_data,
    output logic        s1_ready,
    output logic        m_valid,
    output logic [23:0] m_code,
    output logic        m_src,
    input  logic        m_ready
`ifdef IFNS_ENC_ARB_STATS_EN
    ,
    input  logic        cnt_clr,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]  state_r;
    logic        last_r;
    logic [23:0] m_code_r;
    logic        m_src_r;
    logic        grant_s;
    logic        accept_s;
    logic [16:0] sel_data_s;
    logic [23:0] enc_code_s;

    // Round-robin grant: on contention the requester that did not win last time goes next
    always_comb begin
        grant_s = 1'b0;
        if (s0_valid && s1_valid) begin
            grant_s = ~last_r;
        end else if (s1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // rst_n gates accept so no ready is shown while the block is held in reset
    assign accept_s   = rst_n & en & ((state_r == EMPTY) | m_ready) & (s0_valid | s1_valid);
    assign sel_data_s = grant_s ? s1_data : s0_data;
    assign s0_ready   = accept_s & ~grant_s;
    assign s1_ready   = accept_s & grant_s;

    encoderIFNS_17di_core u_core (
        .data (sel_data_s),
        .code (enc_code_s)
    );

    // Output register, FSM and round-robin pointer; accept wins over drain for no-bubble replace
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            last_r   <= 1'b1;
            m_code_r <= 24'd0;
            m_src_r  <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_r  <= FULL;
                        last_r   <= grant_s;
                        m_code_r <= enc_code_s;
                        m_src_r  <= grant_s;
                    end
                end
                FULL: begin
                    if (accept_s) begin
                        last_r   <= grant_s;
                        m_code_r <= enc_code_s;
                        m_src_r  <= grant_s;
                    end else if (m_ready) begin
                        state_r <= EMPTY;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign m_valid = (state_r == FULL);
    assign m_code  = m_code_r;
    assign m_src   = m_src_r;

`ifdef IFNS_ENC_ARB_STATS_EN
    logic [15:0] cnt0_r;
    logic [15:0] cnt1_r;

    // Saturating per-requester accept counters; clear has priority over counting
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else if (cnt_clr) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else begin
            if (s0_ready && (cnt0_r != 16'hFFFF)) begin
                cnt0_r <= cnt0_r + 16'd1;
            end
            if (s1_ready && (cnt1_r != 16'hFFFF)) begin
                cnt1_r <= cnt1_r + 16'd1;
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`endif

endmodule

// File: tb/tb_ifns_enc_arb.sv
// Directed, scoreboard-based bench for ifns_enc_arb; the counter section is built with IFNS_ENC_ARB_STATS_EN.

module tb_ifns_enc_arb;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        s0_valid = 1'b0;
    logic [16:0] s0_data = 17'd0;
    logic        s0_ready;
    logic        s1_valid = 1'b0;
    logic [16:0] s1_data = 17'd0;
    logic        s1_ready;
    logic        m_valid;
    logic [23:0] m_code;
    logic        m_src;
    logic        m_ready = 1'b0;
`ifdef IFNS_ENC_ARB_STATS_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int checks = 0;
    int failures = 0;

    logic [24:0] sb_q[$];
    logic        mdl_valid = 1'b0;
    logic        mdl_last = 1'b1;
    logic        mdl_src = 1'b0;
    logic [23:0] mdl_code = 24'd0;

    ifns_enc_arb dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .en       (en),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_code   (m_code),
        .m_src    (m_src),
        .m_ready  (m_ready)
`ifdef IFNS_ENC_ARB_STATS_EN
        ,
        .cnt_clr  (cnt_clr),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    always #5 clock = ~clock;

    // Reference encoder: each data bit is placed at its slot and folded into every covering check bit
    function automatic logic [23:0] ref_enc(input logic [16:0] d);
        logic [23:0] c;
        int          pos;
        c   = 24'd0;
        pos = 2;
        for (int k = 0; k < 17; k++) begin
            pos++;
            while ((pos == 4) || (pos == 8) || (pos == 16)) pos++;
            c[pos-1] = d[k];
            for (int b = 0; b < 5; b++) begin
                if (((pos >> b) & 1) == 1) c[(1 << b) - 1] = c[(1 << b) - 1] ^ d[k];
            end
        end
        c[22] = ~(^d);
        c[23] = ^c[22:0];
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic v0, input logic [16:0] d0,
                        input logic v1, input logic [16:0] d1, input logic mr);
        logic        acc;
        logic        g;
        logic [24:0] item;
        @(negedge clock);
        en = e; s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1; m_ready = mr;
        #1;
        acc = e && (!mdl_valid || mr) && (v0 || v1);
        g   = (v0 && v1) ? ~mdl_last : v1;
        check("s0_ready", {31'd0, s0_ready}, {31'd0, acc && !g});
        check("s1_ready", {31'd0, s1_ready}, {31'd0, acc && g});
        if (acc) sb_q.push_back({g, ref_enc(g ? d1 : d0)});
        @(posedge clock);
        #1;
        if (acc) begin
            item      = sb_q.pop_front();
            mdl_last  = g;
            mdl_valid = 1'b1;
            mdl_src   = item[24];
            mdl_code  = item[23:0];
        end else if (mdl_valid && mr) begin
            mdl_valid = 1'b0;
        end
        check("m_valid", {31'd0, m_valid}, {31'd0, mdl_valid});
        check("m_src", {31'd0, m_src}, {31'd0, mdl_src});
        check("m_code", {8'd0, m_code}, {8'd0, mdl_code});
    endtask

    task automatic model_reset();
        mdl_valid = 1'b0;
        mdl_last  = 1'b1;
        mdl_src   = 1'b0;
        mdl_code  = 24'd0;
        sb_q.delete();
    endtask

    initial begin
        // Held in reset with traffic present: nothing accepted, outputs cleared
        s0_valid = 1'b1; s1_valid = 1'b1; en = 1'b1; m_ready = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_code", {8'd0, m_code}, 32'd0);
        check("rst_m_src", {31'd0, m_src}, 32'd0);
        check("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        check("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
`ifdef IFNS_ENC_ARB_STATS_EN
        check("rst_cnt0", {16'd0, cnt0}, 32'd0);
`endif
        rst_n = 1'b1;

        // First accept right after release, known codeword for data 1
        step(1'b1, 1'b1, 17'h00001, 1'b0, 17'h00000, 1'b1);
        check("first_code_const", {8'd0, m_code}, 32'h0080_0007);
        check("first_src", {31'd0, m_src}, 32'd0);

        // Point last at requester 1, then contention alternates 0,1,0,1
        step(1'b1, 1'b0, 17'h00000, 1'b1, 17'h1ABCD, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 17'h00100 + 17'(i), 1'b1, 17'h10000 + 17'(i), 1'b1);
            check("rr_seq", {31'd0, m_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        // Back-pressure: held codeword, requester 1 waits, then goes in the draining cycle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 17'h00000, 1'b1, 17'h05A5A, 1'b0);
        step(1'b1, 1'b0, 17'h00000, 1'b1, 17'h05A5A, 1'b1);
        check("bp_src", {31'd0, m_src}, 32'd1);

        // en low: one drain, then empty with no readies, then en restores accepts
        step(1'b0, 1'b1, 17'h1FFFF, 1'b1, 17'h0F0F0, 1'b1);
        check("en0_drained", {31'd0, m_valid}, 32'd0);
        step(1'b0, 1'b1, 17'h1FFFF, 1'b1, 17'h0F0F0, 1'b1);
        step(1'b1, 1'b1, 17'h1FFFF, 1'b1, 17'h0F0F0, 1'b0);
        step(1'b1, 1'b1, 17'h12345, 1'b0, 17'h00000, 1'b0);

        // Asynchronous reset mid-cycle while full, then requester 0 wins contention
        @(negedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_m_valid", {31'd0, m_valid}, 32'd0);
        check("async_m_code", {8'd0, m_code}, 32'd0);
        model_reset();
        @(posedge clock);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 17'h0AAAA, 1'b1, 17'h15555, 1'b1);
        check("post_rst_src", {31'd0, m_src}, 32'd0);

`ifdef IFNS_ENC_ARB_STATS_EN
        // Saturation of cnt0 and clear-over-accept priority
        cnt_clr = 1'b1;
        step(1'b1, 1'b0, 17'h00000, 1'b0, 17'h00000, 1'b1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 65534; i++) step(1'b1, 1'b1, 17'h00042, 1'b0, 17'h00000, 1'b1);
        check("cnt0_preset", {16'd0, cnt0}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 17'h00043, 1'b0, 17'h00000, 1'b1);
        check("cnt0_sat", {16'd0, cnt0}, 32'h0000_FFFF);
        check("cnt1_idle", {16'd0, cnt1}, 32'd0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 17'h00044, 1'b0, 17'h00000, 1'b1);
        cnt_clr = 1'b0;
        check("cnt0_clr", {16'd0, cnt0}, 32'd0);
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
